// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared FSM state type and frame-length decode for shift_controller.
// Contents:
//   state_t  - IDLE, LOAD, SHIFT, CAPTURE, DONE
//   eff_len  - maps a requested frame length to the number of bits actually shifted
package shift_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, DONE} state_t;

    // A zero or oversize request means a full-width frame.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned size);
        return (len == 0 || len > size) ? size : len;
    endfunction

endpackage

// File: rtl/shift_register.sv
// shift_register: universal shift register driven by shift_controller (MSB-first, left shift).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - parallel load of data_in (takes priority over en)
//   en        - shift left one bit, ser_in enters at bit 0
//   ser_in    - serial input
//   data_in   - parallel load word
//   ser_out   - serial output (current MSB)
//   data_out  - register contents
module shift_register #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            en,
    input  logic            ser_in,
    input  logic [SIZE-1:0] data_in,
    output logic            ser_out,
    output logic [SIZE-1:0] data_out
);

    always_ff @(posedge clk or posedge rst)
        if (rst) data_out <= '0;
        else if (load) data_out <= data_in;
        else if (en) data_out <= {data_out[SIZE-2:0], ser_in};

    assign ser_out = data_out[SIZE-1];

endmodule

// File: rtl/shift_tick_gen.sv
// shift_tick_gen: divides clk down to one shift tick every CLK_DIV cycles.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   restart   - reload the divider so the first tick lands CLK_DIV cycles later
//   tick      - high in cycles where the divider counter is zero
module shift_tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (restart || tick) cnt <= RELOAD;
        else cnt <= cnt - 1'b1;

    assign tick = cnt == '0;

endmodule

// File: rtl/shift_controller.sv
// shift_controller: frame sequencer for one shift_register (load, shift L bits, capture).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   tx_valid/tx_ready   - host offers a word; accepted only in IDLE
//   tx_data, tx_len     - word to load and bits to shift (0 or >SIZE means SIZE)
//   abort               - drops an in-flight frame (LOAD/SHIFT/CAPTURE) back to IDLE
//   rx_valid/rx_ready   - captured word handshake, rx_data held until accepted
//   busy                - high in every state except IDLE
//   sr_load, sr_en      - shift_register controls
//   sr_dataIn           - load word, zero outside LOAD
//   sr_dataOut          - shift_register contents
//   cs_n                - only when SHIFT_CTRL_CS_EN is defined: low for LOAD/SHIFT/CAPTURE
module shift_controller
    import shift_ctrl_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int CLK_DIV = 1,
    parameter int LEN_W   = $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [SIZE-1:0]  tx_data,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             abort,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [SIZE-1:0]  rx_data,
    output logic             busy,
    output logic             sr_load,
    output logic             sr_en,
    output logic [SIZE-1:0]  sr_dataIn,
`ifdef SHIFT_CTRL_CS_EN
    output logic             cs_n,
`endif
    input  logic [SIZE-1:0]  sr_dataOut
);

    state_t           state, next;
    logic [SIZE-1:0]  word;
    logic [LEN_W-1:0] bit_cnt;
    logic             tick;

    shift_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (state == LOAD),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = tx_valid ? LOAD : IDLE;
            LOAD:    next = abort ? IDLE : SHIFT;
            // the tick that issues the last shift also ends the SHIFT state
            SHIFT:   next = abort ? IDLE : (tick && bit_cnt == LEN_W'(1)) ? CAPTURE : SHIFT;
            CAPTURE: next = abort ? IDLE : DONE;
            DONE:    next = rx_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        tx_ready  = state == IDLE;
        busy      = state != IDLE;
        rx_valid  = state == DONE;
        sr_load   = state == LOAD && !abort;
        sr_en     = state == SHIFT && tick && !abort;
        sr_dataIn = state == LOAD ? word : '0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            word    <= '0;
            bit_cnt <= '0;
            rx_data <= '0;
        end else begin
            if (state == IDLE && tx_valid) begin
                word    <= tx_data;
                bit_cnt <= LEN_W'(eff_len(32'(tx_len), SIZE));
            end else if (sr_en) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (state == CAPTURE && !abort) rx_data <= sr_dataOut;
        end

`ifdef SHIFT_CTRL_CS_EN
    // registered from next so it falls together with the entry to LOAD
    always_ff @(posedge clk or posedge rst)
        if (rst) cs_n <= 1'b1;
        else cs_n <= !(next inside {LOAD, SHIFT, CAPTURE});
`endif

endmodule

// File: tb/tb_shift_controller.sv
// tb_shift_controller: self-checking bench for shift_controller with two shift_register pairs
// (CLK_DIV=1 and CLK_DIV=3). Honours SHIFT_CTRL_CS_EN for the cs_n output.
module tb_shift_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic [7:0] tx_data  [2];
    logic [3:0] tx_len   [2];
    logic       abort    [2];
    logic       rx_valid [2];
    logic       rx_ready [2];
    logic [7:0] rx_data  [2];
    logic       busy     [2];
    logic       sr_load  [2];
    logic       sr_en    [2];
    logic [7:0] sr_din   [2];
    logic [7:0] sr_dout  [2];
    logic       loop     [2];
`ifdef SHIFT_CTRL_CS_EN
    logic       cs_n     [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        logic so, si;
        assign si = loop[g] & so;
        shift_controller #(.SIZE(8), .CLK_DIV(g == 0 ? 1 : 3)) dut (
            .clk        (clk),
            .rst        (rst),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready[g]),
            .tx_data    (tx_data[g]),
            .tx_len     (tx_len[g]),
            .abort      (abort[g]),
            .rx_valid   (rx_valid[g]),
            .rx_ready   (rx_ready[g]),
            .rx_data    (rx_data[g]),
            .busy       (busy[g]),
            .sr_load    (sr_load[g]),
            .sr_en      (sr_en[g]),
            .sr_dataIn  (sr_din[g]),
`ifdef SHIFT_CTRL_CS_EN
            .cs_n       (cs_n[g]),
`endif
            .sr_dataOut (sr_dout[g])
        );
        shift_register #(.SIZE(8)) sr (
            .clk      (clk),
            .rst      (rst),
            .load     (sr_load[g]),
            .en       (sr_en[g]),
            .ser_in   (si),
            .data_in  (sr_din[g]),
            .ser_out  (so),
            .data_out (sr_dout[g])
        );
    end

    typedef struct {
        int         k;
        logic [7:0] d;
        logic [3:0] len;
        bit         lp;
        int         hold;
        logic [7:0] exp;
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int div(input int k);
        return k == 0 ? 1 : 3;
    endfunction

    function automatic int eff(input logic [3:0] len);
        return (len == 0 || len > 8) ? 8 : int'(len);
    endfunction

    // Expected capture: shift left by L, refilled with the outgoing bits (loopback) or zeros.
    function automatic logic [7:0] ref_rx(input logic [7:0] d, input logic [3:0] len, input bit lp);
        logic [15:0] w;
        w = {8'h00, d} << eff(len);
        return lp ? (w[7:0] | w[15:8]) : w[7:0];
    endfunction

    task automatic run_frame(input int k, input logic [7:0] d, input logic [3:0] len, input bit lp,
                             input int hold, input logic [7:0] exp, input string nm);
        int l, n, en_n, bad, first_rv, ld_n, ld_at, rdy_bad, hold_bad;
        logic [7:0] din_at_load;
        logic cs_load, cs_done;
        l = eff(len);
        loop[k] = lp;
        rx_ready[k] = 1'b0;
        n = 0;
        while (!tx_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " idle"}, 32'(tx_ready[k]), 32'd1);
        tx_valid[k] = 1'b1;
        tx_data[k]  = d;
        tx_len[k]   = len;
        @(posedge clk);
        en_n = 0; bad = 0; first_rv = 0; ld_n = 0; ld_at = 0; rdy_bad = 0;
        din_at_load = '0; cs_load = 1'b1; cs_done = 1'b0;
        for (n = 1; n <= 5 + l * div(k) && first_rv == 0; n++) begin
            @(negedge clk);
            if (sr_load[k]) begin
                ld_n++;
                ld_at = n;
                din_at_load = sr_din[k];
            end
            if (sr_en[k]) begin
                en_n++;
                if (n != 1 + en_n * div(k)) bad++;
            end
            if (tx_ready[k]) rdy_bad++;
            if (rx_valid[k]) first_rv = n;
`ifdef SHIFT_CTRL_CS_EN
            if (n == 1) cs_load = cs_n[k];
            if (rx_valid[k]) cs_done = cs_n[k];
`endif
        end
        chk({nm, " load_count"}, 32'(ld_n), 32'd1);
        chk({nm, " load_cycle"}, 32'(ld_at), 32'd1);
        chk({nm, " load_word"}, 32'(din_at_load), 32'(d));
        chk({nm, " en_count"}, 32'(en_n), 32'(l));
        chk({nm, " en_timing_errs"}, 32'(bad), 32'd0);
        chk({nm, " rx_valid_cycle"}, 32'(first_rv), 32'(3 + l * div(k)));
        chk({nm, " tx_ready_while_busy"}, 32'(rdy_bad), 32'd0);
        chk({nm, " rx_data"}, 32'(rx_data[k]), 32'(exp));
`ifdef SHIFT_CTRL_CS_EN
        chk({nm, " cs_n_load"}, 32'(cs_load), 32'd0);
        chk({nm, " cs_n_done"}, 32'(cs_done), 32'd1);
`endif
        // DONE holds the word; tx_valid stays high and abort pulses, both must be ignored.
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            abort[k] = i[0];
            @(negedge clk);
            if (!rx_valid[k] || rx_data[k] !== exp || tx_ready[k]) hold_bad++;
        end
        if (hold > 0) chk({nm, " hold_stable_errs"}, 32'(hold_bad), 32'd0);
        abort[k] = 1'b0;
        rx_ready[k] = 1'b1;
        @(negedge clk);
        chk({nm, " release_rx_valid"}, 32'(rx_valid[k]), 32'd0);
        chk({nm, " release_tx_ready"}, 32'(tx_ready[k]), 32'd1);
        chk({nm, " release_busy"}, 32'(busy[k]), 32'd0);
        tx_valid[k] = 1'b0;
        rx_ready[k] = 1'b0;
    endtask

    // Start a frame and abort it in cycle na after the handshake (1 = LOAD).
    task automatic abort_at(input int k, input int na, input string nm);
        int en_n, rv, exp_en;
        loop[k] = 1'b0;
        tx_valid[k] = 1'b1;
        tx_data[k] = 8'hF0;
        tx_len[k] = 4'd8;
        @(posedge clk);
        en_n = 0;
        for (int n = 1; n < na; n++) begin
            @(negedge clk);
            tx_valid[k] = 1'b0;
            if (sr_en[k]) en_n++;
        end
        @(negedge clk);
        tx_valid[k] = 1'b0;
        abort[k] = 1'b1;
        #1;
        chk({nm, " en_gated"}, 32'(sr_en[k]), 32'd0);
        chk({nm, " load_gated"}, 32'(sr_load[k]), 32'd0);
        exp_en = na < 2 ? 0 : (na - 2) / div(k);
        if (exp_en > 8) exp_en = 8;
        chk({nm, " en_before"}, 32'(en_n), 32'(exp_en));
        @(negedge clk);
        abort[k] = 1'b0;
        chk({nm, " busy"}, 32'(busy[k]), 32'd0);
        chk({nm, " tx_ready"}, 32'(tx_ready[k]), 32'd1);
        chk({nm, " rx_valid"}, 32'(rx_valid[k]), 32'd0);
`ifdef SHIFT_CTRL_CS_EN
        chk({nm, " cs_n"}, 32'(cs_n[k]), 32'd1);
`endif
        en_n = 0;
        rv = 0;
        repeat (10) begin
            @(negedge clk);
            if (sr_en[k]) en_n++;
            if (rx_valid[k]) rv++;
        end
        chk({nm, " en_after"}, 32'(en_n), 32'd0);
        chk({nm, " rv_after"}, 32'(rv), 32'd0);
    endtask

    task automatic chk_reset(input int k, input string nm);
        chk({nm, " tx_ready"}, 32'(tx_ready[k]), 32'd1);
        chk({nm, " busy"}, 32'(busy[k]), 32'd0);
        chk({nm, " rx_valid"}, 32'(rx_valid[k]), 32'd0);
        chk({nm, " sr_load"}, 32'(sr_load[k]), 32'd0);
        chk({nm, " sr_en"}, 32'(sr_en[k]), 32'd0);
        chk({nm, " sr_dataIn"}, 32'(sr_din[k]), 32'd0);
        chk({nm, " rx_data"}, 32'(rx_data[k]), 32'd0);
`ifdef SHIFT_CTRL_CS_EN
        chk({nm, " cs_n"}, 32'(cs_n[k]), 32'd1);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [3:0] len;
        bit lp;
        int k;
        vec[0] = '{0, 8'hAA, 4'd8,  1'b1, 0, 8'hAA};
        vec[1] = '{0, 8'hAA, 4'd4,  1'b0, 0, 8'hA0};
        vec[2] = '{0, 8'hAA, 4'd0,  1'b0, 0, 8'h00};
        vec[3] = '{1, 8'hAA, 4'd8,  1'b1, 0, 8'hAA};
        vec[4] = '{0, 8'h3C, 4'd9,  1'b1, 5, 8'h3C};
        vec[5] = '{0, 8'h81, 4'd1,  1'b1, 0, 8'h03};
        vec[6] = '{1, 8'hC3, 4'd5,  1'b0, 5, 8'h60};
        vec[7] = '{1, 8'h96, 4'd15, 1'b1, 2, 8'h96};
        for (int i = 0; i < 2; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = '0;
            tx_len[i]   = '0;
            abort[i]    = 1'b0;
            rx_ready[i] = 1'b0;
            loop[i]     = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_reset(0, "reset0");
        chk_reset(1, "reset1");
        rst = 1'b0;
        @(negedge clk);
        chk_reset(0, "post_release0");
        for (int i = 0; i < 8; i++)
            run_frame(vec[i].k, vec[i].d, vec[i].len, vec[i].lp, vec[i].hold, vec[i].exp,
                      $sformatf("vec%0d", i));
        abort_at(0, 1, "abort_load");
        abort_at(0, 3, "abort_shift");
        abort_at(0, 10, "abort_capture");
        abort_at(1, 11, "abort_after_3rd");
        for (int i = 0; i < 20; i++) begin
            k   = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            len = 4'($urandom_range(0, 15));
            lp  = 1'($urandom_range(0, 1));
            run_frame(k, d, len, lp, int'($urandom_range(0, 3)), ref_rx(d, len, lp),
                      $sformatf("rand%0d", i));
        end
        loop[1] = 1'b1;
        tx_valid[1] = 1'b1;
        tx_data[1] = 8'hC3;
        tx_len[1] = 4'd8;
        @(posedge clk);
        @(negedge clk);
        tx_valid[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_shift busy", 32'(busy[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset(1, "async_rst1");
        chk_reset(0, "async_rst0");
        @(negedge clk);
        rst = 1'b0;
        run_frame(1, 8'h55, 4'd8, 1'b1, 0, 8'h55, "post_rst");
        run_frame(0, 8'h55, 4'd3, 1'b0, 1, ref_rx(8'h55, 4'd3, 1'b0), "post_rst0");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
